// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: stage 1 captures operands, stage 2 computes and
// registers the result with carry/zero/negative/overflow flags.
module alu_pipe #(
   parameter  int WIDTH = 4,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             negative,
   output logic             overflow
);

   localparam int MSB = WIDTH - 1;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [2:0]       s1_sel;

   logic             adv2;
   logic             in_fire;

   logic [SHW-1:0]   amt;
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH:0]   diff_ext;
   logic [WIDTH:0]   shl_ext;
   logic [WIDTH:0]   shr_ext;
   logic [WIDTH-1:0] nxt_result;
   logic             nxt_carry;
   logic             nxt_overflow;

   assign adv2     = !out_valid || out_ready;
   assign in_ready = !s1_valid || adv2;
   assign in_fire  = in_valid && in_ready;

   // Stage 1 empties when it hands off to stage 2 unless refilled on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
      end else if (adv2) begin
         s1_valid <= 1'b0;
      end
   end

   // NOTE: operand registers are deliberately left unreset; s1_valid alone qualifies them.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         s1_a   <= A;
         s1_b   <= B;
         s1_sel <= sel;
      end
   end

   // Extra top bit of the sum/difference holds carry/borrow; the shift
   // extensions catch the last bit shifted out, which is 0 for amount 0.
   assign amt      = s1_b[SHW-1:0];
   assign sum_ext  = {1'b0, s1_a} + {1'b0, s1_b};
   assign diff_ext = {1'b0, s1_a} - {1'b0, s1_b};
   assign shl_ext  = {1'b0, s1_a} << amt;
   assign shr_ext  = {s1_a, 1'b0} >> amt;

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      nxt_result   = s1_a;
      nxt_carry    = 1'b0;
      nxt_overflow = 1'b0;
      case (s1_sel)
         OP_AND: nxt_result = s1_a & s1_b;
         OP_OR:  nxt_result = s1_a | s1_b;
         OP_ADD: begin
            nxt_result   = sum_ext[MSB:0];
            nxt_carry    = sum_ext[WIDTH];
            nxt_overflow = (s1_a[MSB] == s1_b[MSB]) && (sum_ext[MSB] != s1_a[MSB]);
         end
         OP_SUB: begin
            nxt_result   = diff_ext[MSB:0];
            nxt_carry    = diff_ext[WIDTH];
            nxt_overflow = (s1_a[MSB] != s1_b[MSB]) && (diff_ext[MSB] != s1_a[MSB]);
         end
         OP_XOR: nxt_result = s1_a ^ s1_b;
         OP_SHL: begin
            nxt_result = shl_ext[MSB:0];
            nxt_carry  = shl_ext[WIDTH];
         end
         OP_SHR: begin
            nxt_result = shr_ext[WIDTH:1];
            nxt_carry  = shr_ext[0];
         end
         default: nxt_result = s1_a;
      endcase
   end

   // Data only reloads with a real op, so flags stay steady while out_valid is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         carry     <= 1'b0;
         zero      <= 1'b0;
         negative  <= 1'b0;
         overflow  <= 1'b0;
      end else if (adv2) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            result   <= nxt_result;
            carry    <= nxt_carry;
            zero     <= (nxt_result == '0);
            negative <= nxt_result[MSB];
            overflow <= nxt_overflow;
         end
      end
   end

endmodule
